// File: rtl/conv_pkg.sv
// Shared widths, FSM encoding and descriptor layout for the conv layer sequencer.
package conv_pkg;

  localparam int unsigned TENSOR_W   = 8;
  localparam int unsigned KERNEL_W   = 4;
  localparam int unsigned CH_W       = 8;
  localparam int unsigned STRIDE_W   = 3;
  localparam int unsigned KNUM_W     = 8;
  localparam int unsigned MAX_LAYERS = 8;
  localparam int unsigned LIDX_W     = $clog2(MAX_LAYERS);

  typedef enum logic [4:0] {
    ST_IDLE  = 5'b00001,
    ST_CALC  = 5'b00010,
    ST_ISSUE = 5'b00100,
    ST_WAIT  = 5'b01000,
    ST_DONE  = 5'b10000
  } state_e;

  typedef struct packed {
    logic [KERNEL_W-1:0] kernel_size;
    logic [STRIDE_W-1:0] stride;
    logic [KNUM_W-1:0]   kernel_nums;
  } desc_t;

endpackage

// File: rtl/conv_geom_div.sv
// Iterative subtract divider producing ofs = (T-K)/S + 1, one subtraction per cycle.
// The first cycle (start_i) works on T-K directly, so the result is ready after
// floor((T-K)/S)+1 cycles counting the start cycle.
module conv_geom_div
  import conv_pkg::*;
#(
  parameter int unsigned TW = TENSOR_W,
  parameter int unsigned KW = KERNEL_W,
  parameter int unsigned SW = STRIDE_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable_i,
  input  logic          calc_i,
  input  logic          start_i,
  input  logic [TW-1:0] tensor_i,
  input  logic [KW-1:0] kernel_i,
  input  logic [SW-1:0] stride_i,
  output logic [TW-1:0] ofs_c_o,
  output logic          valid_c_o,
  output logic          err_c_o
);

  logic [TW-1:0] diff_q;
  logic [TW-1:0] quot_q;
  logic [TW-1:0] work_diff;
  logic [TW-1:0] work_quot;
  logic          step;

  // Select fresh operands on the start cycle, otherwise continue the running division
  always_comb begin
    work_diff = start_i ? (tensor_i - TW'(kernel_i)) : diff_q;
    work_quot = start_i ? '0 : quot_q;
    err_c_o   = start_i && ((TW'(kernel_i) > tensor_i) || (stride_i == '0));
    step      = (work_diff >= TW'(stride_i));
    valid_c_o = !err_c_o && !step;
    ofs_c_o   = work_quot + TW'(1);
  end

  // Remainder/quotient registers advance only while the sequencer is calculating
  always_ff @(posedge clk) begin
    if (rst) begin
      diff_q <= '0;
      quot_q <= '0;
    end else if (enable_i && calc_i && !err_c_o && step) begin
      diff_q <= work_diff - TW'(stride_i);
      quot_q <= work_quot + TW'(1);
    end
  end

endmodule

// File: rtl/conv_layer_seq.sv
// Multi-layer conv control: walks a descriptor table, computes each layer's
// output geometry, starts the engine and chains geometry into the next layer.
module conv_layer_seq
  import conv_pkg::*;
#(
  parameter int unsigned TENSOR_W   = conv_pkg::TENSOR_W,
  parameter int unsigned KERNEL_W   = conv_pkg::KERNEL_W,
  parameter int unsigned CH_W       = conv_pkg::CH_W,
  parameter int unsigned STRIDE_W   = conv_pkg::STRIDE_W,
  parameter int unsigned KNUM_W     = conv_pkg::KNUM_W,
  parameter int unsigned MAX_LAYERS = conv_pkg::MAX_LAYERS,
  parameter int unsigned LIDX_W     = $clog2(MAX_LAYERS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic                           cfg_we,
  input  logic [LIDX_W-1:0]              cfg_idx,
  input  logic [KERNEL_W-1:0]            cfg_kernel_size,
  input  logic [STRIDE_W-1:0]            cfg_stride,
  input  logic [KNUM_W-1:0]              cfg_kernel_nums,
  input  logic [TENSOR_W-1:0]            base_tensor_size,
  input  logic [CH_W-1:0]                base_channels,
  input  logic [LIDX_W:0]                num_layers,
  input  logic                           run,
  input  logic                           abort,
  input  logic                           eng_done,
  output logic [TENSOR_W-1:0]            tensor_size,
  output logic [KERNEL_W-1:0]            kernel_size,
  output logic [CH_W-1:0]                channels,
  output logic [STRIDE_W-1:0]            stride,
  output logic [KNUM_W-1:0]              kernel_nums,
  output logic [TENSOR_W-1:0]            ofs,
  output logic [2*TENSOR_W+KNUM_W-1:0]   ifmap_num,
  output logic [LIDX_W-1:0]              layer_idx,
  output logic                           start_conv,
  output logic                           busy,
  output logic                           seq_done,
  output logic                           err
);

  localparam int unsigned IFM_W = 2*TENSOR_W + KNUM_W;
  localparam int unsigned NUM_W = LIDX_W + 1;

  state_e                state_q, state_d;
  desc_t                 tbl_q [MAX_LAYERS];
  logic [TENSOR_W-1:0]   tensor_q, tensor_d;
  logic [KERNEL_W-1:0]   kernel_q, kernel_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [STRIDE_W-1:0]   stride_q, stride_d;
  logic [KNUM_W-1:0]     kn_q, kn_d;
  logic [TENSOR_W-1:0]   ofs_q, ofs_d;
  logic [IFM_W-1:0]      ifmap_q, ifmap_d;
  logic [LIDX_W-1:0]     idx_q, idx_d;
  logic [NUM_W-1:0]      num_q, num_d;
  logic                  err_q, err_d;
  logic                  first_q, first_d;
  logic [LIDX_W-1:0]     idx_next;
  logic                  last_layer;
  logic                  div_start;
  logic [TENSOR_W-1:0]   div_ofs;
  logic                  div_valid;
  logic                  div_err;

  assign idx_next   = idx_q + LIDX_W'(1);
  assign last_layer = ({1'b0, idx_q} == (num_q - NUM_W'(1)));
  assign div_start  = (state_q == ST_CALC) && first_q;

  conv_geom_div #(
    .TW (TENSOR_W),
    .KW (KERNEL_W),
    .SW (STRIDE_W)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .enable_i  (enable),
    .calc_i    (state_q == ST_CALC),
    .start_i   (div_start),
    .tensor_i  (tensor_q),
    .kernel_i  (kernel_q),
    .stride_i  (stride_q),
    .ofs_c_o   (div_ofs),
    .valid_c_o (div_valid),
    .err_c_o   (div_err)
  );

  // Descriptor table: written from the config side only while idle
  always_ff @(posedge clk) begin
    if (enable && cfg_we && (state_q == ST_IDLE)) begin
      tbl_q[cfg_idx] <= '{kernel_size: cfg_kernel_size,
                          stride:      cfg_stride,
                          kernel_nums: cfg_kernel_nums};
    end
  end

  // Next-state and register-update logic for the layer sequencer
  always_comb begin
    state_d  = state_q;
    tensor_d = tensor_q;
    kernel_d = kernel_q;
    ch_d     = ch_q;
    stride_d = stride_q;
    kn_d     = kn_q;
    ofs_d    = ofs_q;
    ifmap_d  = ifmap_q;
    idx_d    = idx_q;
    num_d    = num_q;
    err_d    = err_q;
    first_d  = first_q;
    if (enable) begin
      first_d = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!abort && run) begin
            if ((num_layers == '0) || (num_layers > NUM_W'(MAX_LAYERS))) begin
              err_d = 1'b1;
            end else begin
              err_d    = 1'b0;
              idx_d    = '0;
              num_d    = num_layers;
              tensor_d = base_tensor_size;
              ch_d     = base_channels;
              kernel_d = tbl_q[0].kernel_size;
              stride_d = tbl_q[0].stride;
              kn_d     = tbl_q[0].kernel_nums;
              first_d  = 1'b1;
              state_d  = ST_CALC;
            end
          end
        end
        ST_CALC: begin
          if (abort) begin
            state_d = ST_IDLE;
          end else if (div_err) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
          end else if (div_valid) begin
            ofs_d   = div_ofs;
            state_d = ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (abort) begin
            state_d = ST_IDLE;
          end else begin
            ifmap_d = IFM_W'(ofs_q) * IFM_W'(ofs_q) * IFM_W'(kn_q);
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (abort) begin
            state_d = ST_IDLE;
          end else if (eng_done) begin
            if (last_layer) begin
              state_d = ST_DONE;
            end else begin
              idx_d    = idx_next;
              tensor_d = ofs_q;
              ch_d     = CH_W'(kn_q);
              kernel_d = tbl_q[idx_next].kernel_size;
              stride_d = tbl_q[idx_next].stride;
              kn_d     = tbl_q[idx_next].kernel_nums;
              first_d  = 1'b1;
              state_d  = ST_CALC;
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      tensor_q <= '0;
      kernel_q <= '0;
      ch_q     <= '0;
      stride_q <= '0;
      kn_q     <= '0;
      ofs_q    <= '0;
      ifmap_q  <= '0;
      idx_q    <= '0;
      num_q    <= '0;
      err_q    <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tensor_q <= tensor_d;
      kernel_q <= kernel_d;
      ch_q     <= ch_d;
      stride_q <= stride_d;
      kn_q     <= kn_d;
      ofs_q    <= ofs_d;
      ifmap_q  <= ifmap_d;
      idx_q    <= idx_d;
      num_q    <= num_d;
      err_q    <= err_d;
      first_q  <= first_d;
    end
  end

  // Strobes are state decodes suppressed by a same-cycle abort or a frozen enable
  assign start_conv  = enable && !abort && (state_q == ST_ISSUE);
  assign seq_done    = enable && !abort && (state_q == ST_DONE);
  assign busy        = (state_q != ST_IDLE);
  assign tensor_size = tensor_q;
  assign kernel_size = kernel_q;
  assign channels    = ch_q;
  assign stride      = stride_q;
  assign kernel_nums = kn_q;
  assign ofs         = ofs_q;
  assign ifmap_num   = ifmap_q;
  assign layer_idx   = idx_q;
  assign err         = err_q;

endmodule
